// File: rtl/data_mem_sub_if.sv
// data_mem_sub bus: pc/A/WD/WE/RE/op request from master,
// RD/rd_valid/adel/ades response from slave.
interface data_mem_sub_if;
  logic [31:0] pc;
  logic [31:0] A;
  logic [31:0] WD;
  logic        WE;
  logic        RE;
  logic [2:0]  op;
  logic [31:0] RD;
  logic        rd_valid;
  logic        adel;
  logic        ades;

  modport master (
    output pc, A, WD, WE, RE, op,
    input  RD, rd_valid, adel, ades
  );

  modport slave (
    input  pc, A, WD, WE, RE, op,
    output RD, rd_valid, adel, ades
  );
endinterface

// File: rtl/data_mem_sub.sv
// Sub-word data memory: byte/half/word stores, extended registered loads,
// address-error flags. Ports: clk, reset (sync, high), bus (slave).
// Optional store trace when DM_TRACE_EN is defined.
module data_mem_sub #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic          clk,
  input  logic          reset,
  data_mem_sub_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  logic [31:0] rd_q;
  logic        vld_q;
  logic        adel_q;
  logic        ades_q;

  logic is_w, is_h, is_b, sgn, rsv;
  logic mis, oor, fault, st_ok;
  logic [ADDR_WIDTH-1:0] widx;
  logic [31:0] old_w, merged, src, ld;
  logic [3:0]  be;
  logic [31:0] wrep;
  logic [7:0]  bsel;
  logic [15:0] hsel;

  assign widx = bus.A[ADDR_WIDTH+1:2];
  assign old_w = mem[widx];

  always_comb begin
    is_w = 1'b0;
    is_h = 1'b0;
    is_b = 1'b0;
    sgn  = 1'b0;
    rsv  = 1'b0;
    unique case (1'b1)
      (bus.op == 3'b000): is_w = 1'b1;
      (bus.op == 3'b001): is_h = 1'b1;
      (bus.op == 3'b010): begin
        is_h = 1'b1;
        sgn  = 1'b1;
      end
      (bus.op == 3'b011): is_b = 1'b1;
      (bus.op == 3'b100): begin
        is_b = 1'b1;
        sgn  = 1'b1;
      end
      default: rsv = 1'b1;
    endcase
  end

  assign mis = rsv
             | (is_w & (|bus.A[1:0]))
             | (is_h & bus.A[0]);
  assign oor = (bus.A >> (ADDR_WIDTH + 2)) != 32'd0;
  assign fault = mis | oor;
  assign st_ok = bus.WE & ~fault;

  always_comb begin
    be   = 4'h0;
    wrep = 32'h0;
    unique case (1'b1)
      is_w: begin
        be   = 4'hF;
        wrep = bus.WD;
      end
      is_h: begin
        be   = bus.A[1] ? 4'hC : 4'h3;
        wrep = {2{bus.WD[15:0]}};
      end
      is_b: begin
        be   = 4'b0001 << bus.A[1:0];
        wrep = {4{bus.WD[7:0]}};
      end
      default: begin
        be   = 4'h0;
        wrep = 32'h0;
      end
    endcase
  end

  always_comb begin
    merged = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wrep[8*i +: 8];
    end
  end

  // write-first: a same-cycle load sees the store's merged word
  assign src  = st_ok ? merged : old_w;
  assign bsel = src[{bus.A[1:0], 3'b000} +: 8];
  assign hsel = bus.A[1] ? src[31:16] : src[15:0];

  always_comb begin
    ld = 32'h0;
    unique case (1'b1)
      is_w: ld = src;
      is_h: ld = {{16{sgn & hsel[15]}}, hsel};
      is_b: ld = {{24{sgn & bsel[7]}}, bsel};
      default: ld = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
      rd_q   <= 32'h0;
      vld_q  <= 1'b0;
      adel_q <= 1'b0;
      ades_q <= 1'b0;
    end else begin
      if (st_ok) mem[widx] <= merged;
      if (bus.RE) rd_q <= fault ? 32'h0 : ld;
      vld_q  <= bus.RE;
      adel_q <= bus.RE & fault;
      ades_q <= bus.WE & fault;
    end
  end

  assign bus.RD       = rd_q;
  assign bus.rd_valid = vld_q;
  assign bus.adel     = adel_q;
  assign bus.ades     = ades_q;

`ifdef DM_TRACE_EN
  always @(posedge clk) begin
    if (!reset && st_ok)
      $display("%d@%h: *%h <= %h", $time, bus.pc,
               {bus.A[31:2], 2'b00}, merged);
  end
`else
  logic unused_pc;
  assign unused_pc = ^bus.pc;
`endif

endmodule

// File: tb/tb_data_mem_sub.sv
// Directed bench for data_mem_sub.
// Drives the bus interface, checks outputs 1 time unit after each edge.
module tb_data_mem_sub;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  data_mem_sub_if bus ();

  data_mem_sub #(.ADDR_WIDTH(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] W   = 3'b000;
  localparam logic [2:0] HU  = 3'b001;
  localparam logic [2:0] HS  = 3'b010;
  localparam logic [2:0] BU  = 3'b011;
  localparam logic [2:0] BS  = 3'b100;
  localparam logic [2:0] RSV = 3'b101;

  task automatic cyc(input logic we, input logic re,
                     input logic [2:0] o,
                     input logic [31:0] a,
                     input logic [31:0] wd);
    bus.WE = we;
    bus.RE = re;
    bus.op = o;
    bus.A  = a;
    bus.WD = wd;
    bus.pc = 32'h0040_0000 + a;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ld(input string tag,
                        input logic [31:0] rd,
                        input logic v, input logic e);
    chk({tag, ".RD"}, bus.RD, rd);
    chk({tag, ".vld"}, {31'b0, bus.rd_valid}, {31'b0, v});
    chk({tag, ".adel"}, {31'b0, bus.adel}, {31'b0, e});
  endtask

  task automatic chk_ades(input string tag, input logic e);
    chk({tag, ".ades"}, {31'b0, bus.ades}, {31'b0, e});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.WE = 1'b0;
    bus.RE = 1'b0;
    bus.op = W;
    bus.A  = '0;
    bus.WD = '0;
    bus.pc = '0;

    // reset, with a store and load that must be ignored
    reset = 1'b1;
    cyc(1, 1, W, 32'h0, 32'h5);
    chk_ld("rst", 32'h0, 0, 0);
    chk_ades("rst", 0);
    reset = 1'b0;

    cyc(0, 1, W, 32'h0, 0);
    chk_ld("clr0", 32'h0, 1, 0);
    cyc(0, 1, W, 32'hFFC, 0);
    chk_ld("clrFFC", 32'h0, 1, 0);
    cyc(0, 0, W, 32'h0, 0);
    chk_ld("idle", 32'h0, 0, 0);

    // word then byte merge
    cyc(1, 0, W, 32'h10, 32'h1122_3344);
    chk_ades("sw10", 0);
    cyc(1, 0, BU, 32'h12, 32'h0000_00AA);
    chk_ades("sb12", 0);
    cyc(0, 1, W, 32'h10, 0);
    chk_ld("lw10", 32'h11AA_3344, 1, 0);

    // sign / zero extension
    cyc(1, 0, W, 32'h20, 32'h80FF_7F01);
    cyc(0, 1, BS, 32'h22, 0);
    chk_ld("lb22", 32'hFFFF_FFFF, 1, 0);
    cyc(0, 1, BU, 32'h23, 0);
    chk_ld("lbu23", 32'h0000_0080, 1, 0);
    cyc(0, 1, HS, 32'h22, 0);
    chk_ld("lh22", 32'hFFFF_80FF, 1, 0);
    cyc(0, 1, HU, 32'h20, 0);
    chk_ld("lhu20", 32'h0000_7F01, 1, 0);
    cyc(0, 1, BS, 32'h21, 0);
    chk_ld("lb21", 32'h0000_007F, 1, 0);

    // halfword store into upper lanes
    cyc(1, 0, HU, 32'h52, 32'hFFFF_BEEF);
    cyc(0, 1, W, 32'h50, 0);
    chk_ld("lw50", 32'hBEEF_0000, 1, 0);
    cyc(0, 1, HS, 32'h52, 0);
    chk_ld("lh52", 32'hFFFF_BEEF, 1, 0);

    // misalignment
    cyc(1, 0, W, 32'h30, 32'hCAFE_F00D);
    cyc(1, 0, HU, 32'h31, 32'h0000_5555);
    chk_ades("sh31", 1);
    cyc(0, 0, W, 32'h0, 0);
    chk_ades("sh31.pulse", 0);
    cyc(0, 1, W, 32'h30, 0);
    chk_ld("lw30", 32'hCAFE_F00D, 1, 0);
    cyc(0, 1, W, 32'h32, 0);
    chk_ld("lw32", 32'h0, 1, 1);
    cyc(0, 1, RSV, 32'h30, 0);
    chk_ld("rsv30", 32'h0, 1, 1);
    cyc(0, 0, W, 32'h0, 0);
    chk_ld("idle2", 32'h0, 0, 0);

    // out of range store must not alias word 0
    cyc(1, 0, W, 32'h1000, 32'h1234_5678);
    chk_ades("sw1000", 1);
    cyc(0, 1, W, 32'h0, 0);
    chk_ld("lw0", 32'h0, 1, 0);
    chk_ades("sw1000.pulse", 0);
    cyc(0, 1, W, 32'h1000, 0);
    chk_ld("lw1000", 32'h0, 1, 1);

    // simultaneous store + load, write-first
    cyc(1, 1, W, 32'h40, 32'hDEAD_BEEF);
    chk_ld("swlw40", 32'hDEAD_BEEF, 1, 0);
    chk_ades("swlw40", 0);
    cyc(1, 1, BU, 32'h41, 32'h0000_0077);
    chk_ld("sblbu41", 32'h0000_0077, 1, 0);

    // back-to-back loads
    cyc(0, 1, W, 32'h10, 0);
    chk_ld("b2b0", 32'h11AA_3344, 1, 0);
    cyc(0, 1, W, 32'h20, 0);
    chk_ld("b2b1", 32'h80FF_7F01, 1, 0);
    cyc(0, 1, W, 32'h40, 0);
    chk_ld("b2b2", 32'hDEAD_77EF, 1, 0);

    // reset right after a load clears valid and the array
    reset = 1'b1;
    cyc(0, 0, W, 32'h0, 0);
    chk_ld("rst2", 32'h0, 0, 0);
    reset = 1'b0;
    cyc(0, 1, W, 32'h40, 0);
    chk_ld("rst2.lw40", 32'h0, 1, 0);
    cyc(0, 0, W, 32'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
